snake_step_sched: RTL and testbench
===================================

# snake_step_sched

Game-step scheduler for the two-player snake datapath. Generates the periodic game tick and waits for vertical blank so the board is never modified while the VGA reader scans it. It then sequences one step request to each snake update engine over a req/ack handshake, supplying a filtered direction. It collects collision results, drives the game stage and winner, and handles restart.

## Interface
Parameters:
- TICK_CYCLES, 1000000: clock cycles between game steps; legal range 2..2^32-1.
- ACK_TIMEOUT, 255: maximum cycles to wait for an engine ack; only used with SNAKE_STEP_TIMEOUT_EN.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- vblank  in  1  high while the display is not reading the board.
- restart  in  1  level; leaves game-over.
- move1, move2  in  32  player direction code: 1 up, 2 right, 3 down, 4 left; any other value means no change.
- step1_req, step2_req  out  1  step request to snake engine 1 or 2.
- step1_dir, step2_dir  out  3  direction for that step; stable while the matching req is high.
- step1_ack, step2_ack  in  1  engine finished the step.
- step1_collide, step2_collide  in  1  collision result; valid only while the matching ack is high.
- init  out  1  one-cycle pulse ordering the engines to reload their start positions.
- stage  out  2  2 = play, 3 = game over.
- winner  out  2  0 none, 1 snake1, 2 snake2, 3 draw.
- isDrawing  out  1  high except in IDLE; gates board writes elsewhere.
- step_count  out  16  completed steps since the last restart; wraps.

## Operation
- FSM states: IDLE, SYNC, REQ1, REQ2, EVAL, OVER.
- IDLE: tick counter increments each cycle. When it reaches TICK_CYCLES-1, the counter clears and the FSM goes to SYNC.
- SYNC: wait for vblank = 1, then go to REQ1. Directions are latched here, once per step:
  - A new move is accepted only if it is a legal code and not the reverse of the current direction (1↔3, 2↔4).
  - Otherwise the current direction is kept.
- REQ1: step1_req = 1 with step1_dir. Stay until step1_ack = 1. Capture step1_collide on that cycle, then go to REQ2.
- REQ2: same handshake for engine 2, then go to EVAL.
- EVAL, one cycle:
  - step_count increments.
  - If neither snake collided: go to IDLE.
  - Otherwise set winner: 1 if only snake2 collided, 2 if only snake1 collided, 3 if both. Set stage = 3 and go to OVER.
- OVER: engines are idle. When restart = 1:
  - Directions reset to 2 (snake1) and 4 (snake2); winner = 0; step_count = 0; tick counter = 0; stage = 2.
  - init pulses for one cycle; the FSM goes to IDLE.
- restart in any state other than OVER is ignored.
- An ack without a matching req is ignored.

## Timing
- Reset values:
  - Outputs: step*_req = 0, init = 0, stage = 2, winner = 0, isDrawing = 0, step_count = 0.
  - Internal: dir1 = 2, dir2 = 4, FSM = IDLE, counter = 0.
- Tick period when vblank is already high and acks are immediate: TICK_CYCLES + 5 cycles from one IDLE entry to the next (SYNC, REQ1, REQ2, EVAL, and the counter wrap).
- Handshake rules:
  - req rises on the cycle after entering REQx.
  - An ack sampled high on a posedge drops req on that same edge.
  - Acks arriving in the same cycle as req rises are legal.
  - The engine must drop ack before the next request.
- Both requests are never high together; snake1 is always served first.
- isDrawing rises on IDLE exit and falls on IDLE entry.
- Reset asserted mid-handshake: req drops asynchronously and any partial step is discarded.

## Configuration
- SNAKE_STEP_TIMEOUT_EN defined: a per-request counter runs while in REQx. If ack is not seen within ACK_TIMEOUT cycles, the FSM treats that snake as collided and proceeds, dropping req on the expiry cycle.
- SNAKE_STEP_TIMEOUT_EN undefined: REQx waits indefinitely; ACK_TIMEOUT is unused.

## Test plan
- Basic step: TICK_CYCLES = 10, vblank = 1, acks returned 1 cycle after req, no collisions → step1_req then step2_req pulse every 15 cycles; step_count increments 0, 1, 2; stage stays 2.
- Vblank wait: tick expires with vblank = 0 for 40 cycles → no req until the cycle after vblank rises; isDrawing high throughout the wait.
- Direction filter: dir1 = 2; move1 = 4 → step1_dir stays 2. move1 = 1 → 1. move1 = 7 → stays 1.
- Collision and restart:
  - step2_collide = 1 only → winner = 1, stage = 3, no further requests.
  - restart = 1 → stage = 2, winner = 0, init pulses for 1 cycle, dirs reset to 2 and 4.
- Draw: both collide in the same step → winner = 3, stage = 3.
- Timeout (macro on, ACK_TIMEOUT = 8): step1_ack held at 0 → step1_req drops after 8 cycles; step2 is still served; winner = 2. Asserting reset during REQ2 → all outputs return to reset values immediately.

Source files
------------

// File: rtl/snake_step_sched.sv
// rtl/snake_step_sched.sv - game-step scheduler for the two-player snake datapath
//
// Purpose: produces the periodic game tick, waits for vertical blank, then
// sequences one step request to snake engine 1 and then snake engine 2 over a
// req/ack handshake. It supplies each engine with a filtered direction,
// collects the collision results and drives stage, winner and restart.
//
// Ports:
//   clock, reset                  system clock, asynchronous active-high reset
//   vblank                        high while the display is not reading the board
//   restart                       level, leaves game-over
//   move1, move2        [31:0]    direction codes 1 up, 2 right, 3 down, 4 left
//   step1_req/step2_req           step request to engine 1 / engine 2
//   step1_dir/step2_dir [2:0]     direction for the step, stable while req high
//   step1_ack/step2_ack           engine finished the step
//   step1_collide/step2_collide   collision result, valid while ack high
//   init                          one-cycle pulse, engines reload start positions
//   stage               [1:0]     2 play, 3 game over
//   winner              [1:0]     0 none, 1 snake1, 2 snake2, 3 draw
//   isDrawing                     high except in IDLE
//   step_count          [15:0]    completed steps since last restart, wraps
//
// Optional feature: define SNAKE_STEP_TIMEOUT_EN to give up on an engine that
// does not ack within ACK_TIMEOUT request cycles; that snake counts as collided.

module snake_step_sched #(
   parameter int unsigned TICK_CYCLES = 1000000,
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        vblank,
   input  logic        restart,
   input  logic [31:0] move1,
   input  logic [31:0] move2,
   output logic        step1_req,
   output logic        step2_req,
   output logic [2:0]  step1_dir,
   output logic [2:0]  step2_dir,
   input  logic        step1_ack,
   input  logic        step2_ack,
   input  logic        step1_collide,
   input  logic        step2_collide,
   output logic        init,
   output logic [1:0]  stage,
   output logic [1:0]  winner,
   output logic        isDrawing,
   output logic [15:0] step_count
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_SYNC = 3'd1,
      S_REQ1 = 3'd2,
      S_REQ2 = 3'd3,
      S_EVAL = 3'd4,
      S_OVER = 3'd5
   } state_t;

   // IDLE ends when the counter reaches TICK_CYCLES-1, so IDLE lasts
   // TICK_CYCLES-1 cycles; with SYNC, two-cycle REQ phases and EVAL the
   // step period with instant acks is TICK_CYCLES+5.
   localparam logic [31:0] TICK_LAST = 32'(TICK_CYCLES - 1);

   state_t      r_state;
   state_t      w_next;

   logic [31:0] r_tick;
   logic [31:0] w_tick_inc;
   logic        w_tick_wrap;

   logic [2:0]  r_dir1;
   logic [2:0]  r_dir2;
   logic        r_req1;
   logic        r_req2;
   logic        r_col1;
   logic        r_col2;
   logic        r_init;
   logic [1:0]  r_stage;
   logic [1:0]  r_winner;
   logic [15:0] r_steps;

   logic        w_ack1;
   logic        w_ack2;
   logic        w_done1;
   logic        w_done2;
   logic        w_col1_now;
   logic        w_col2_now;

   // A move is taken only if it is a legal code and not a U-turn.
   function automatic logic [2:0] f_filter(input logic [2:0] cur, input logic [31:0] mv);
      logic [2:0] rev;
      rev = (cur > 3'd2) ? (cur - 3'd2) : (cur + 3'd2);
      f_filter = cur;
      if ((mv >= 32'd1) && (mv <= 32'd4) && (mv[2:0] != rev)) begin
         f_filter = mv[2:0];
      end
   endfunction

   assign w_tick_inc  = r_tick + 32'd1;
   assign w_tick_wrap = (w_tick_inc == TICK_LAST);

   // Acks only count while the matching request is actually raised.
   assign w_ack1 = r_req1 & step1_ack;
   assign w_ack2 = r_req2 & step2_ack;

`ifdef SNAKE_STEP_TIMEOUT_EN
   localparam logic [31:0] TO_LAST = 32'(ACK_TIMEOUT - 1);

   logic [31:0] r_to;
   logic        w_expire;

   // Counts cycles with a request raised; cleared whenever no request is open.
   assign w_expire = (r_req1 | r_req2) & (r_to == TO_LAST);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_to <= '0;
      end else if ((r_req1 & ~w_done1) | (r_req2 & ~w_done2)) begin
         r_to <= r_to + 32'd1;
      end else begin
         r_to <= '0;
      end
   end

   // A real ack on the expiry cycle wins over the timeout.
   assign w_done1    = w_ack1 | (r_req1 & w_expire);
   assign w_done2    = w_ack2 | (r_req2 & w_expire);
   assign w_col1_now = (w_ack1 & step1_collide) | (r_req1 & w_expire & ~w_ack1);
   assign w_col2_now = (w_ack2 & step2_collide) | (r_req2 & w_expire & ~w_ack2);
`else
   logic w_unused_ack_timeout;
   assign w_unused_ack_timeout = (ACK_TIMEOUT != 0);

   assign w_done1    = w_ack1;
   assign w_done2    = w_ack2;
   assign w_col1_now = w_ack1 & step1_collide;
   assign w_col2_now = w_ack2 & step2_collide;
`endif

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_tick_wrap) w_next = S_SYNC;
         S_SYNC: if (vblank)      w_next = S_REQ1;
         S_REQ1: if (w_done1)     w_next = S_REQ2;
         S_REQ2: if (w_done2)     w_next = S_EVAL;
         S_EVAL: w_next = (r_col1 | r_col2) ? S_OVER : S_IDLE;
         S_OVER: if (restart)     w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      isDrawing = (r_state != S_IDLE);
   end

   // Datapath: tick counter, requests, directions, results
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_tick   <= '0;
         r_dir1   <= 3'd2;
         r_dir2   <= 3'd4;
         r_req1   <= 1'b0;
         r_req2   <= 1'b0;
         r_col1   <= 1'b0;
         r_col2   <= 1'b0;
         r_init   <= 1'b0;
         r_stage  <= 2'd2;
         r_winner <= 2'd0;
         r_steps  <= '0;
      end else begin
         r_init <= 1'b0;

         // Requests are computed from the current state, so they rise one
         // cycle after the FSM enters REQx and drop on the completing edge.
         r_req1 <= (r_state == S_REQ1) & ~w_done1;
         r_req2 <= (r_state == S_REQ2) & ~w_done2;

         if (r_state == S_IDLE) begin
            r_tick <= w_tick_wrap ? 32'd0 : w_tick_inc;
         end

         if ((r_state == S_SYNC) && vblank) begin
            r_dir1 <= f_filter(r_dir1, move1);
            r_dir2 <= f_filter(r_dir2, move2);
         end

         if ((r_state == S_REQ1) && w_done1) begin
            r_col1 <= w_col1_now;
         end
         if ((r_state == S_REQ2) && w_done2) begin
            r_col2 <= w_col2_now;
         end

         if (r_state == S_EVAL) begin
            r_steps <= r_steps + 16'd1;
            if (r_col1 | r_col2) begin
               // {col1, col2}: snake2 only -> 1, snake1 only -> 2, both -> 3
               r_winner <= {r_col1, r_col2};
               r_stage  <= 2'd3;
            end
         end

         if ((r_state == S_OVER) && restart) begin
            r_dir1   <= 3'd2;
            r_dir2   <= 3'd4;
            r_winner <= 2'd0;
            r_steps  <= '0;
            r_tick   <= '0;
            r_stage  <= 2'd2;
            r_init   <= 1'b1;
         end
      end
   end

   assign step1_req  = r_req1;
   assign step2_req  = r_req2;
   assign step1_dir  = r_dir1;
   assign step2_dir  = r_dir2;
   assign init       = r_init;
   assign stage      = r_stage;
   assign winner     = r_winner;
   assign step_count = r_steps;

endmodule

// File: tb/tb_snake_step_sched.sv
// tb/tb_snake_step_sched.sv - self-checking bench for snake_step_sched
module tb_snake_step_sched;

   localparam int unsigned TICK  = 10;
   localparam int unsigned ATO   = 8;
   localparam int          LIMIT = 200;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        vblank = 1'b1;
   logic        restart = 1'b0;
   logic [31:0] move1 = '0;
   logic [31:0] move2 = '0;
   logic        step1_ack = 1'b0;
   logic        step2_ack = 1'b0;
   logic        step1_collide = 1'b0;
   logic        step2_collide = 1'b0;
   logic        step1_req;
   logic        step2_req;
   logic [2:0]  step1_dir;
   logic [2:0]  step2_dir;
   logic        init;
   logic [1:0]  stage;
   logic [1:0]  winner;
   logic        isDrawing;
   logic [15:0] step_count;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   snake_step_sched #(.TICK_CYCLES(TICK), .ACK_TIMEOUT(ATO)) dut (
      .clock(clock), .reset(reset), .vblank(vblank), .restart(restart),
      .move1(move1), .move2(move2),
      .step1_req(step1_req), .step2_req(step2_req),
      .step1_dir(step1_dir), .step2_dir(step2_dir),
      .step1_ack(step1_ack), .step2_ack(step2_ack),
      .step1_collide(step1_collide), .step2_collide(step2_collide),
      .init(init), .stage(stage), .winner(winner),
      .isDrawing(isDrawing), .step_count(step_count)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] m1;
      logic [31:0] m2;
      int          d1;
      int          d2;
      logic        c1;
      logic        c2;
      logic [2:0]  e_dir1;
      logic [2:0]  e_dir2;
      logic [1:0]  e_win;
      logic [1:0]  e_stage;
   } vec_t;

   vec_t tbl [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Engine model: wait for req, hold ack off for dly cycles, then ack once.
   task automatic serve(input int eng, input int dly, input logic col,
                        input logic [2:0] edir, output int t_rise);
      int n;
      logic [2:0] d;
      n = 0;
      while (((eng == 1) ? step1_req : step2_req) !== 1'b1 && n < LIMIT) begin
         @(negedge clock);
         n++;
      end
      t_rise = cyc;
      check($sformatf("req%0d_seen", eng), (n < LIMIT), 1);
      check($sformatf("req%0d_other_low", eng), (eng == 1) ? step2_req : step1_req, 0);
      d = (eng == 1) ? step1_dir : step2_dir;
      check($sformatf("dir%0d", eng), d, edir);
      repeat (dly) @(negedge clock);
      if (dly > 0) check($sformatf("req%0d_held", eng), (eng == 1) ? step1_req : step2_req, 1);
      if (eng == 1) begin
         step1_ack = 1'b1; step1_collide = col;
      end else begin
         step2_ack = 1'b1; step2_collide = col;
      end
      @(negedge clock);
      check($sformatf("req%0d_drop", eng), (eng == 1) ? step1_req : step2_req, 0);
      step1_ack = 1'b0; step1_collide = 1'b0;
      step2_ack = 1'b0; step2_collide = 1'b0;
   endtask

   initial begin
      int rise;
      int prev_rise;
      int bad;
      int n;

      //        m1      m2        d1 d2 c1 c2 dir1 dir2 win stage
      tbl[0] = '{32'd0, 32'd0,   0, 0, 0, 0, 3'd2, 3'd4, 2'd0, 2'd2};
      tbl[1] = '{32'd4, 32'd2,   1, 0, 0, 0, 3'd2, 3'd4, 2'd0, 2'd2};
      tbl[2] = '{32'd1, 32'd3,   0, 2, 0, 0, 3'd1, 3'd3, 2'd0, 2'd2};
      tbl[3] = '{32'd7, 32'd257, 3, 1, 0, 0, 3'd1, 3'd3, 2'd0, 2'd2};
      tbl[4] = '{32'd3, 32'd1,   0, 0, 0, 0, 3'd1, 3'd3, 2'd0, 2'd2};
      tbl[5] = '{32'd2, 32'd4,   0, 0, 0, 0, 3'd2, 3'd4, 2'd0, 2'd2};
      tbl[6] = '{32'd0, 32'd0,   0, 0, 0, 1, 3'd2, 3'd4, 2'd1, 2'd3};

      #1 reset = 1'b1;
      @(negedge clock);
      check("rst_req1", step1_req, 0);
      check("rst_req2", step2_req, 0);
      check("rst_init", init, 0);
      check("rst_stage", stage, 2);
      check("rst_winner", winner, 0);
      check("rst_drawing", isDrawing, 0);
      check("rst_count", step_count, 0);
      check("rst_dir1", step1_dir, 2);
      check("rst_dir2", step2_dir, 4);
      @(negedge clock);
      reset = 1'b0;

      prev_rise = 0;
      for (int i = 0; i < 7; i++) begin
         move1 = tbl[i].m1;
         move2 = tbl[i].m2;
         serve(1, tbl[i].d1, tbl[i].c1, tbl[i].e_dir1, rise);
         if (i > 0) check($sformatf("period_%0d", i), rise - prev_rise,
                          15 + tbl[i-1].d1 + tbl[i-1].d2);
         prev_rise = rise;
         serve(2, tbl[i].d2, tbl[i].c2, tbl[i].e_dir2, rise);
         @(negedge clock);
         check($sformatf("count_%0d", i), step_count, i + 1);
         check($sformatf("winner_%0d", i), winner, tbl[i].e_win);
         check($sformatf("stage_%0d", i), stage, tbl[i].e_stage);
         check($sformatf("drawing_%0d", i), isDrawing, (tbl[i].e_stage == 2'd3));
      end

      // Game over: engines stay idle.
      bad = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clock);
         if (step1_req || step2_req || stage != 2'd3) bad++;
      end
      check("over_quiet", bad, 0);

      // Restart; held high into IDLE where it must be ignored.
      restart = 1'b1;
      @(negedge clock);
      check("rs_init", init, 1);
      check("rs_stage", stage, 2);
      check("rs_winner", winner, 0);
      check("rs_count", step_count, 0);
      check("rs_drawing", isDrawing, 0);
      check("rs_dir1", step1_dir, 2);
      check("rs_dir2", step2_dir, 4);
      @(negedge clock);
      check("rs_init_pulse", init, 0);

      // Vblank wait.
      move1 = 32'd1;
      move2 = 32'd3;
      vblank = 1'b0;
      n = 0;
      while (!isDrawing && n < LIMIT) begin
         @(negedge clock);
         n++;
      end
      check("vb_sync_seen", (n < LIMIT), 1);
      bad = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clock);
         if (step1_req || step2_req || !isDrawing) bad++;
      end
      check("vb_wait", bad, 0);
      vblank = 1'b1;
      @(negedge clock);
      check("vb_req_entry", step1_req, 0);
      @(negedge clock);
      check("vb_req_rise", step1_req, 1);
      serve(1, 0, 1'b0, 3'd1, rise);
      serve(2, 0, 1'b0, 3'd3, rise);
      @(negedge clock);
      check("vb_count", step_count, 1);
      check("vb_stage", stage, 2);
      restart = 1'b0;

      // Draw.
      serve(1, 0, 1'b1, 3'd1, rise);
      serve(2, 0, 1'b1, 3'd3, rise);
      @(negedge clock);
      check("draw_winner", winner, 3);
      check("draw_stage", stage, 3);
      check("draw_count", step_count, 2);

      restart = 1'b1;
      @(negedge clock);
      restart = 1'b0;
      check("rs2_count", step_count, 0);

      // One clean step, then reset while engine 2 has not acked.
      serve(1, 0, 1'b0, 3'd1, rise);
      serve(2, 0, 1'b0, 3'd3, rise);
      @(negedge clock);
      check("pre_rst_count", step_count, 1);
      serve(1, 0, 1'b0, 3'd1, rise);
      n = 0;
      while (!step2_req && n < LIMIT) begin
         @(negedge clock);
         n++;
      end
      check("hang_req2_seen", (n < LIMIT), 1);
      repeat (3) @(negedge clock);
      reset = 1'b1;
      #1;
      check("mid_req1", step1_req, 0);
      check("mid_req2", step2_req, 0);
      check("mid_init", init, 0);
      check("mid_stage", stage, 2);
      check("mid_winner", winner, 0);
      check("mid_drawing", isDrawing, 0);
      check("mid_count", step_count, 0);
      check("mid_dir1", step1_dir, 2);
      check("mid_dir2", step2_dir, 4);
      @(negedge clock);
      reset = 1'b0;
      move1 = 32'd0;
      move2 = 32'd0;

`ifdef SNAKE_STEP_TIMEOUT_EN
      n = 0;
      while (!step1_req && n < LIMIT) begin
         @(negedge clock);
         n++;
      end
      check("to_req1_seen", (n < LIMIT), 1);
      n = 0;
      while (step1_req && n < 50) begin
         n++;
         @(negedge clock);
      end
      check("to_req1_len", n, ATO);
      serve(2, 0, 1'b0, 3'd4, rise);
      @(negedge clock);
      check("to_winner", winner, 2);
      check("to_stage", stage, 3);
      check("to_count", step_count, 1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
